btn_event_ctrl: RTL and testbench
=================================

// Module: btn_event_ctrl
// PURPOSE
//  Shared-timebase debounce and event scheduler for N push-buttons. Synchronises raw inputs, debounces each channel
//  against a common tick prescaler, and serialises press/release events to one valid/ready event port
//  via a round-robin arbiter. Sits between board buttons and the lab-level control FSMs.
// PARAMETERS
//  N_BTN        4       number of button channels (2..16)
//  TICK_DIV     100000  clk cycles per debounce tick (1 ms @ 100 MHz); >= 2
//  STABLE_TICKS 10      ticks a new level must hold before acceptance; >= 1
//  REPEAT_DELAY 500     ticks held before first auto-repeat (BTN_REPEAT_EN only)
//  REPEAT_RATE  100     ticks between auto-repeats (BTN_REPEAT_EN only)
// PORTS
//  clk          in   1               system clock, all logic on posedge
//  reset_n      in   1               asynchronous active-low reset
//  btn_raw      in   N_BTN           raw asynchronous button inputs, 1 = pressed
//  btn_state    out  N_BTN           debounced level per channel
//  evt_valid    out  1               event offered
//  evt_ready    in   1               consumer accepts event when evt_valid & evt_ready
//  evt_id       out  $clog2(N_BTN)   channel of offered event
//  evt_press    out  1               1 = press, 0 = release
//  evt_repeat   out  1               1 = auto-repeat press; tied 0 without BTN_REPEAT_EN
//  evt_overrun  out  1               sticky: a pending event was overwritten before issue
//  clr_overrun  in   1               synchronous clear of evt_overrun
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0, synchronisers/counters/pending flags 0, prescaler 0, last_grant=N_BTN-1.
//    Reset mid-offer drops evt_valid immediately; all pending events are discarded.
//  - Sync: 2-FF synchroniser per channel; debounce logic sees btn_raw delayed 2 clk.
//  - Prescaler: counts 0..TICK_DIV-1, wraps; tick = 1-clk pulse when count==TICK_DIV-1.
//  - Per channel: sync==btn_state -> counter=0. Else on tick counter+1; when incremented value==STABLE_TICKS:
//    btn_state toggles, counter=0, pend=1, pend_dir=new level. Any glitch back to old level restarts count.
//  - Overrun: new event on channel whose pend==1 -> pend_dir overwritten with newest, evt_overrun=1.
//    Set and clr_overrun in same cycle -> set wins.
//  - Arbiter FSM, 2 states:
//    IDLE : if any pend: grant first pend channel searching from last_grant+1 (mod N_BTN); load evt_id/evt_press/
//           evt_repeat, clear its pend, last_grant=id, evt_valid=1 next clk, -> OFFER. Else stay.
//    OFFER: evt_id/evt_press/evt_repeat stable while evt_valid=1. On evt_valid&evt_ready: evt_valid=0 -> IDLE.
//    Throughput max 1 event / 2 clk. Event latency: grant edge = 1 clk after pend set (IDLE).
//  - Same-cycle pend set by debounce and clear by grant on same channel: grant captures old event, set wins,
//    no overrun flagged.
//  - evt_ready ignored while evt_valid=0; no combinational path evt_ready -> evt_valid.
// CONFIGURATION
//  BTN_REPEAT_EN defined: per-channel repeat counter counts ticks while btn_state=1; after REPEAT_DELAY ticks,
//    then every REPEAT_RATE ticks, raise pend with press=1, repeat=1. Repeat while pend already set is dropped
//    silently (no overrun). Release clears repeat counter.
//  BTN_REPEAT_EN undefined: no repeat logic synthesised; evt_repeat constant 0; REPEAT_* unused.
// TESTING  (bench params N_BTN=4, TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=8, REPEAT_RATE=4)
//  1 btn_raw[1] toggles every 5 clk for 40 clk then held 1, evt_ready=1 -> exactly one event id=1 press=1;
//    btn_state[1] rises 11..14 clk after final edge; no release event.
//  2 btn_raw[0] and [2] rise same clk, evt_ready=1 -> id=0 then id=2, evt_valid pulses 2 clk apart.
//  3 evt_ready=0; ch3 press, release, press (each stable) -> press offered and held stable, evt_overrun=1;
//    ready=1 -> events press,press; clr_overrun -> evt_overrun=0.
//  4 all 4 channels event continuously, evt_ready=1 -> grant order 0,1,2,3,0,... no channel starved.
//  5 reset_n=0 mid OFFER with 2 pend -> evt_valid=0 same clk; after release no events until new input.
//  6 BTN_REPEAT_EN, btn_raw[2] held 1 -> press(repeat=0), then press(repeat=1) after 8 ticks, then every 4 ticks;
//    without macro only the single press.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// Debounce and event scheduler for N push-buttons sharing one tick prescaler.
// Optional auto-repeat is compiled in when BTN_REPEAT_EN is defined.
module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_BTN-1:0]           btn_raw,
  output logic [N_BTN-1:0]           btn_state,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(N_BTN)-1:0]   evt_id,
  output logic                       evt_press,
  output logic                       evt_repeat,
  output logic                       evt_overrun,
  input  logic                       clr_overrun
);

  localparam int ID_W = $clog2(N_BTN);
  localparam int PW   = $clog2(TICK_DIV);
  localparam int CW   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [N_BTN-1:0] r_sync1, r_sync2;
  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [CW-1:0]    r_cnt [N_BTN];
  logic [N_BTN-1:0] r_state;
  logic [N_BTN-1:0] w_db_evt;
  logic [N_BTN-1:0] w_rep_set;
  logic [N_BTN-1:0] r_pend, r_pend_dir;
  logic [N_BTN-1:0] w_grant_clr;
  logic             w_ovr_set;
  logic             r_overrun;
  logic [0:0]       r_fsm;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_evt_id;
  logic             r_evt_press;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_gnt_any;
  logic             w_do_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // A channel accepts its new level on the tick that completes STABLE_TICKS.
  always_comb begin
    w_db_evt = '0;
    for (int i = 0; i < N_BTN; i++)
      w_db_evt[i] = (r_sync2[i] != r_state[i]) && w_tick &&
                    (r_cnt[i] == CW'(STABLE_TICKS - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
      r_state <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_state[i]) begin
          r_cnt[i] <= '0;
        end else if (w_db_evt[i]) begin
          r_cnt[i]   <= '0;
          r_state[i] <= ~r_state[i];
        end else if (w_tick) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // A debounce event beats a same-cycle grant clear; the grant keeps the old event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= '0;
      r_pend_dir <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (w_db_evt[i]) begin
          r_pend[i]     <= 1'b1;
          r_pend_dir[i] <= ~r_state[i];
        end else if (w_rep_set[i]) begin
          r_pend[i]     <= 1'b1;
          r_pend_dir[i] <= 1'b1;
        end else if (w_grant_clr[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  assign w_ovr_set = |(w_db_evt & r_pend & ~w_grant_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_overrun <= 1'b0;
    else if (w_ovr_set)   r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = (int'(r_last) + k) % N_BTN;
      if (!w_gnt_any && r_pend[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'(idx);
      end
    end
  end

  assign w_do_grant  = (r_fsm == S_IDLE) && w_gnt_any;
  assign w_grant_clr = w_do_grant ? (N_BTN'(1) << w_gnt_id) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= S_IDLE;
      r_last      <= ID_W'(N_BTN - 1);
      r_evt_id    <= '0;
      r_evt_press <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_do_grant) begin
            r_evt_id    <= w_gnt_id;
            r_evt_press <= r_pend_dir[w_gnt_id];
            r_last      <= w_gnt_id;
            r_fsm       <= S_OFFER;
          end
        end
        default: begin
          if (evt_ready) r_fsm <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0]    r_rcnt [N_BTN];
  logic [N_BTN-1:0] r_rstarted;
  logic [N_BTN-1:0] r_pend_rep;
  logic [N_BTN-1:0] w_rep_evt;
  logic             r_evt_rep;

  always_comb begin
    w_rep_evt = '0;
    for (int i = 0; i < N_BTN; i++)
      w_rep_evt[i] = r_state[i] && w_tick &&
                     (r_rstarted[i] ? (r_rcnt[i] == RW'(REPEAT_RATE - 1))
                                    : (r_rcnt[i] == RW'(REPEAT_DELAY - 1)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BTN; i++) r_rcnt[i] <= '0;
      r_rstarted <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!r_state[i]) begin
          r_rcnt[i]     <= '0;
          r_rstarted[i] <= 1'b0;
        end else if (w_rep_evt[i]) begin
          r_rcnt[i]     <= '0;
          r_rstarted[i] <= 1'b1;
        end else if (w_tick) begin
          r_rcnt[i] <= r_rcnt[i] + RW'(1);
        end
      end
    end
  end

  // Repeats that find an event still waiting are dropped without flagging overrun.
  assign w_rep_set = w_rep_evt & ~w_db_evt & ~(r_pend & ~w_grant_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_rep <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (w_db_evt[i])       r_pend_rep[i] <= 1'b0;
        else if (w_rep_set[i]) r_pend_rep[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_evt_rep <= 1'b0;
    else if (w_do_grant) r_evt_rep <= r_pend_rep[w_gnt_id];
  end

  assign evt_repeat = r_evt_rep;
`else
  logic w_unused_rep;
  assign w_unused_rep = (REPEAT_DELAY != REPEAT_RATE);
  assign w_rep_set    = '0;
  assign evt_repeat   = 1'b0;
`endif

  assign btn_state   = r_state;
  assign evt_valid   = (r_fsm == S_OFFER);
  assign evt_id      = r_evt_id;
  assign evt_press   = r_evt_press;
  assign evt_overrun = r_overrun;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with a fast tick (TICK_DIV=4, STABLE_TICKS=3).
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn_raw = '0;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_id;
  logic       evt_press;
  logic       evt_repeat;
  logic       evt_overrun;
  logic       clr_overrun = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_id[$], q_press[$], q_rep[$], q_cyc[$];

  btn_event_ctrl #(
    .N_BTN(4), .TICK_DIV(4), .STABLE_TICKS(3), .REPEAT_DELAY(8), .REPEAT_RATE(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .btn_state(btn_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_press(evt_press), .evt_repeat(evt_repeat), .evt_overrun(evt_overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Log every accepted handshake with its cycle stamp.
  always @(posedge clk) begin
    cyc++;
    if (reset_n && evt_valid && evt_ready) begin
      q_id.push_back(int'(evt_id));
      q_press.push_back(int'(evt_press));
      q_rep.push_back(int'(evt_repeat));
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    q_id.delete(); q_press.delete(); q_rep.delete(); q_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; btn_raw = '0; evt_ready = 1'b0; clr_overrun = 1'b0;
    clks(2);
    reset_n = 1'b1;
    clear_log();
    clks(1);
  endtask

  task automatic wait_bit(input int ch, input logic val, input int maxc, output int lat);
    lat = -1;
    for (int n = 1; n <= maxc; n++) begin
      @(negedge clk);
      if (btn_state[ch] === val) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;

    // Reset state
    clks(2);
    chk("rst_state", btn_state, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_press", evt_press, 0);
    chk("rst_repeat", evt_repeat, 0);
    chk("rst_overrun", evt_overrun, 0);

    // 1: bouncing channel 1 settles high
    do_reset();
    evt_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      btn_raw[1] = ~btn_raw[1];
      clks(5);
    end
    chk("t1_no_early_state", btn_state[1], 0);
    chk("t1_no_early_evt", q_id.size(), 0);
    btn_raw[1] = 1'b1;
    wait_bit(1, 1'b1, 30, lat);
    chk("t1_latency_11_14", (lat >= 11 && lat <= 14), 1);
    clks(20);
    chk("t1_state", btn_state, 4'b0010);
    chk("t1_evt_count", q_id.size(), 1);
    if (q_id.size() > 0) begin
      chk("t1_id", q_id[0], 1);
      chk("t1_press", q_press[0], 1);
      chk("t1_repeat", q_rep[0], 0);
    end

    // 2: channels 0 and 2 together
    do_reset();
    evt_ready = 1'b1;
    btn_raw = 4'b0101;
    clks(25);
    chk("t2_state", btn_state, 4'b0101);
    chk("t2_evt_count", q_id.size(), 2);
    if (q_id.size() >= 2) begin
      chk("t2_first_id", q_id[0], 0);
      chk("t2_second_id", q_id[1], 2);
      chk("t2_spacing", q_cyc[1] - q_cyc[0], 2);
      chk("t2_press0", q_press[0], 1);
      chk("t2_press1", q_press[1], 1);
    end

    // 3: overrun on channel 3 while consumer stalls
    do_reset();
    btn_raw[3] = 1'b1;
    wait_bit(3, 1'b1, 30, lat);
    chk("t3_press_seen", (lat > 0), 1);
    clks(3);
    chk("t3_valid_a", evt_valid, 1);
    chk("t3_id_a", evt_id, 3);
    chk("t3_press_a", evt_press, 1);
    btn_raw[3] = 1'b0;
    wait_bit(3, 1'b0, 30, lat);
    clks(2);
    chk("t3_ovr_none", evt_overrun, 0);
    chk("t3_valid_b", evt_valid, 1);
    chk("t3_press_b", evt_press, 1);
    btn_raw[3] = 1'b1;
    wait_bit(3, 1'b1, 30, lat);
    clks(2);
    chk("t3_ovr_set", evt_overrun, 1);
    chk("t3_id_c", evt_id, 3);
    chk("t3_press_c", evt_press, 1);
    evt_ready = 1'b1;
    clks(6);
    chk("t3_evt_count", q_id.size(), 2);
    if (q_id.size() >= 2) begin
      chk("t3_ev0_press", q_press[0], 1);
      chk("t3_ev1_press", q_press[1], 1);
      chk("t3_ev1_id", q_id[1], 3);
    end
    chk("t3_ovr_sticky", evt_overrun, 1);
    clr_overrun = 1'b1;
    clks(1);
    clr_overrun = 1'b0;
    chk("t3_ovr_cleared", evt_overrun, 0);

    // 4: all channels busy, round-robin fairness
    do_reset();
    evt_ready = 1'b1;
    btn_raw = 4'hF;
    clks(20);
    btn_raw = 4'h0;
    clks(20);
    btn_raw = 4'hF;
    clks(30);
    chk("t4_evt_count", q_id.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < q_id.size()) begin
        chk($sformatf("t4_id_%0d", i), q_id[i], i % 4);
        chk($sformatf("t4_press_%0d", i), q_press[i], (i < 4 || i >= 8) ? 1 : 0);
      end
    end
    chk("t4_no_overrun", evt_overrun, 0);

    // 5: reset in the middle of an offer
    do_reset();
    btn_raw = 4'b0111;
    for (int n = 0; n < 30 && !evt_valid; n++) clks(1);
    clks(2);
    chk("t5_valid_before", evt_valid, 1);
    chk("t5_id_before", evt_id, 0);
    reset_n = 1'b0;
    btn_raw = '0;
    #1;
    chk("t5_valid_async", evt_valid, 0);
    chk("t5_state_async", btn_state, 0);
    clks(2);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    clear_log();
    clks(40);
    chk("t5_no_events", q_id.size(), 0);
    chk("t5_valid_idle", evt_valid, 0);
    btn_raw[1] = 1'b1;
    clks(20);
    chk("t5_new_count", q_id.size(), 1);
    if (q_id.size() > 0) chk("t5_new_id", q_id[0], 1);

    // 6: channel 2 held down
    do_reset();
    evt_ready = 1'b1;
    btn_raw[2] = 1'b1;
    clks(90);
`ifdef BTN_REPEAT_EN
    chk("t6_evt_count", q_id.size(), 4);
    if (q_id.size() >= 4) begin
      chk("t6_rep0", q_rep[0], 0);
      chk("t6_rep1", q_rep[1], 1);
      chk("t6_rep3", q_rep[3], 1);
      chk("t6_press1", q_press[1], 1);
      chk("t6_delay", q_cyc[1] - q_cyc[0], 32);
      chk("t6_rate_a", q_cyc[2] - q_cyc[1], 16);
      chk("t6_rate_b", q_cyc[3] - q_cyc[2], 16);
    end
`else
    chk("t6_evt_count", q_id.size(), 1);
    if (q_id.size() > 0) begin
      chk("t6_id", q_id[0], 2);
      chk("t6_press", q_press[0], 1);
      chk("t6_rep", q_rep[0], 0);
    end
    chk("t6_repeat_out", evt_repeat, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
